// File: rtl/ball_move_sched.sv
// ball_move_sched: once per (speed_div+1) frames, strobes each enabled ball in turn and waits for its done.
// Build option MOVE_SCHED_ROTATE_EN rotates the first-served ball by one slot on every sweep.
module ball_move_sched #(
    parameter int N_BALLS = 4,
    parameter int TIMEOUT = 15,
    parameter int IDXW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic               vblank,
    input  logic               run,
    input  logic [3:0]         speed_div,
    input  logic [N_BALLS-1:0] ball_en,
    input  logic [N_BALLS-1:0] ball_done,
    output logic [N_BALLS-1:0] move,
    output logic               busy,
    output logic [IDXW-1:0]    cur_ball,
    output logic               overrun,
    output logic               timeout_err,
    output logic [2:0]         dbg_state
);
    localparam int            SW        = IDXW + 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_BALLS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_vblank_d1;
    logic               r_req_pend;
    logic               r_busy;
    logic               r_overrun;
    logic               r_timeout_err;
    logic [3:0]         r_frame_cnt;
    logic [N_BALLS-1:0] r_mask;
    logic [N_BALLS-1:0] r_move;
    logic [SW-1:0]      r_slot;
    logic [IDXW-1:0]    r_base;
    logic [IDXW-1:0]    r_cur_ball;
    logic [7:0]         r_timer;

    logic               w_frame_start;
    logic               w_vblank_fall;
    logic               w_sweep_req;
    logic               w_go;
    logic [IDXW-1:0]    w_start;
    logic [IDXW-1:0]    w_ball;
    logic [SW-1:0]      w_slot_inc;
    logic [IDXW-1:0]    w_next_ball;
    logic               w_next_valid;
    logic [N_BALLS-1:0] w_onehot;

    // Slot numbers are offsets from the sweep's base ball, wrapped modulo N_BALLS.
    function automatic logic [IDXW-1:0] slot_to_ball(input logic [IDXW-1:0] base,
                                                     input logic [SW-1:0]   slot);
        logic [SW-1:0] sum;
        sum = {1'b0, base} + slot;
        if (sum >= LAST_SLOT) sum = sum - LAST_SLOT;
        return sum[IDXW-1:0];
    endfunction

    assign w_frame_start = vblank & ~r_vblank_d1;
    assign w_vblank_fall = r_vblank_d1 & ~vblank;
    assign w_sweep_req   = w_frame_start && (r_frame_cnt == speed_div);
    assign w_go          = (r_state == S_IDLE) && (w_sweep_req || r_req_pend) && run;
    assign w_ball        = slot_to_ball(r_base, r_slot);
    assign w_slot_inc    = r_slot + SW'(1);
    assign w_next_ball   = slot_to_ball(r_base, w_slot_inc);
    assign w_next_valid  = (w_slot_inc < LAST_SLOT);
    assign w_onehot      = N_BALLS'(1) << w_ball;

`ifdef MOVE_SCHED_ROTATE_EN
    logic [IDXW-1:0] r_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start <= '0;
        end else if (pixpulse && w_go) begin
            r_start <= (r_start == IDXW'(N_BALLS - 1)) ? '0 : r_start + IDXW'(1);
        end
    end

    assign w_start = r_start;
`else
    assign w_start = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_vblank_d1   <= 1'b0;
            r_req_pend    <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_cnt   <= 4'd0;
            r_mask        <= '0;
            r_move        <= '0;
            r_slot        <= '0;
            r_base        <= '0;
            r_cur_ball    <= '0;
            r_timer       <= 8'd0;
        end else if (pixpulse) begin
            r_vblank_d1 <= vblank;
            r_move      <= '0;
            if (w_frame_start) begin
                r_frame_cnt <= (r_frame_cnt == speed_div) ? 4'd0 : r_frame_cnt + 4'd1;
            end
            if (w_vblank_fall && r_busy) r_overrun <= 1'b1;
            if ((r_state != S_IDLE) && w_sweep_req) r_req_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    // A request seen while run=0 is consumed here and never served.
                    if (w_sweep_req || r_req_pend) begin
                        r_req_pend <= 1'b0;
                        if (run) begin
                            r_mask     <= ball_en;
                            r_slot     <= '0;
                            r_base     <= w_start;
                            r_cur_ball <= w_start;
                            r_busy     <= 1'b1;
                            r_state    <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_slot == LAST_SLOT) begin
                        r_state <= S_DONE;
                    end else if (!r_mask[w_ball]) begin
                        r_slot <= w_slot_inc;
                        if (w_next_valid) r_cur_ball <= w_next_ball;
                    end else begin
                        r_move  <= w_onehot;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ball_done[w_ball]) begin
                        r_slot <= w_slot_inc;
                        if (w_next_valid) r_cur_ball <= w_next_ball;
                        if (run) begin
                            r_state <= S_SCAN;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (r_timer == 8'(TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_slot        <= w_slot_inc;
                        if (w_next_valid) r_cur_ball <= w_next_ball;
                        r_state       <= S_SCAN;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign move        = r_move;
    assign busy        = r_busy;
    assign cur_ball    = r_cur_ball;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ball_move_sched.sv
// Directed bench for ball_move_sched: frame division, masks, timeout, overrun, reset and pixpulse gating.
module tb_ball_move_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pixpulse;
    logic         vblank;
    logic         run;
    logic [3:0]   speed_div;
    logic [N-1:0] ball_en;
    logic [N-1:0] ball_done;
    logic [N-1:0] move;
    logic         busy;
    logic [1:0]   cur_ball;
    logic         overrun;
    logic         timeout_err;
    logic [2:0]   dbg_state;

    int           total = 0;
    int           bad   = 0;
    int           cyc_no = 0;
    int           n_moves = 0;
    int           m1_cyc = 0;
    int           m2_cyc = 0;
    int           to_cyc = 0;
    logic         to_seen = 1'b0;
    int           rot_start = 0;
    int           resp_dly = 3;
    logic [N-1:0] resp_en = '1;
    int           dly[N];
    logic [5:0]   exp_q[$];

    ball_move_sched #(.N_BALLS(N), .TIMEOUT(15), .IDXW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixpulse    (pixpulse),
        .vblank      (vblank),
        .run         (run),
        .speed_div   (speed_div),
        .ball_en     (ball_en),
        .ball_done   (ball_done),
        .move        (move),
        .busy        (busy),
        .cur_ball    (cur_ball),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, score move pulses, then drive ball_done for the next edge.
    task automatic cyc();
        logic [N-1:0] m;
        @(negedge clk);
        cyc_no++;
        m = move;
        check("move_onehot0", 32'($onehot0(m)), 32'd1);
        if (m != '0) begin
            n_moves++;
            if (m[1]) m1_cyc = cyc_no;
            if (m[2]) m2_cyc = cyc_no;
            if (exp_q.size() == 0) check("move_unexpected", 32'(m), 32'd0);
            else check("move_seq", 32'({cur_ball, m}), 32'(exp_q.pop_front()));
        end
        if (timeout_err && !to_seen) begin
            to_seen = 1'b1;
            to_cyc  = cyc_no;
        end
        ball_done = '0;
        for (int i = 0; i < N; i++) begin
            if (dly[i] > 0) begin
                dly[i]--;
                if (dly[i] == 0) ball_done[i] = 1'b1;
            end
            if (m[i] && resp_en[i]) dly[i] = resp_dly;
        end
    endtask

    task automatic push_sweep(input logic [N-1:0] en);
        int b;
        for (int s = 0; s < N; s++) begin
            b = (rot_start + s) % N;
            if (en[b]) exp_q.push_back({2'(b), 4'(1 << b)});
        end
`ifdef MOVE_SCHED_ROTATE_EN
        rot_start = (rot_start + 1) % N;
`endif
    endtask

    task automatic frame(input int hi, input int lo);
        n_moves = 0;
        vblank  = 1'b1;
        repeat (hi) cyc();
        vblank  = 1'b0;
        repeat (lo) cyc();
    endtask

    initial begin
        rst = 1'b0; pixpulse = 1'b1; vblank = 1'b0; run = 1'b0;
        speed_div = 4'd0; ball_en = '0; ball_done = '0;
        for (int i = 0; i < N; i++) dly[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_move", 32'(move), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur", 32'(cur_ball), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        repeat (3) cyc();

        // all balls, every frame: latency 2, sweep ends inside vblank
        run = 1'b1; ball_en = 4'hF; speed_div = 4'd0; resp_dly = 3;
        push_sweep(4'hF);
        n_moves = 0;
        vblank = 1'b1;
        cyc();
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_move_early", 32'(move), 32'd0);
        cyc();
        check("lat_move", 32'(move), 32'd1);
        repeat (28) cyc();
        check("busy_before_vb_end", 32'(busy), 32'd0);
        vblank = 1'b0;
        repeat (30) cyc();
        check("all_moves_f1", 32'(n_moves), 32'd4);
        check("no_overrun", 32'(overrun), 32'd0);
        push_sweep(4'hF);
        frame(30, 30);
        check("all_moves_f2", 32'(n_moves), 32'd4);
        check("drain_a", 32'(exp_q.size()), 32'd0);

        // speed_div=2: sweeps only on frames 3, 6, 9
        speed_div = 4'd2;
        for (int f = 1; f <= 9; f++) begin
            if (f % 3 == 0) push_sweep(4'hF);
            frame(30, 10);
            check("div_moves", 32'(n_moves), (f % 3 == 0) ? 32'd4 : 32'd0);
        end
        check("drain_b", 32'(exp_q.size()), 32'd0);

        // sparse mask 0101: cur_ball walks every slot
        speed_div = 4'd0; ball_en = 4'b0101;
        push_sweep(4'b0101);
        n_moves = 0;
        vblank = 1'b1;
        cyc();
`ifndef MOVE_SCHED_ROTATE_EN
        check("cur_step0", 32'(cur_ball), 32'd0);
`endif
        repeat (5) cyc();
`ifndef MOVE_SCHED_ROTATE_EN
        check("cur_step1", 32'(cur_ball), 32'd1);
`endif
        cyc();
`ifndef MOVE_SCHED_ROTATE_EN
        check("cur_step2", 32'(cur_ball), 32'd2);
`endif
        repeat (5) cyc();
`ifndef MOVE_SCHED_ROTATE_EN
        check("cur_step3", 32'(cur_ball), 32'd3);
`endif
        repeat (2) cyc();
        check("mask_busy_hi", 32'(busy), 32'd1);
        cyc();
        check("mask_busy_lo", 32'(busy), 32'd0);
        repeat (15) cyc();
        vblank = 1'b0;
        repeat (10) cyc();
        check("mask_moves", 32'(n_moves), 32'd2);
        check("drain_c", 32'(exp_q.size()), 32'd0);

        // ball 1 never answers: 16 WAIT ticks, timeout flag, then ball 2
        ball_en = 4'hF; resp_en = 4'b1101;
        m1_cyc = 0; m2_cyc = 0; to_seen = 1'b0; to_cyc = 0;
        push_sweep(4'hF);
        frame(45, 15);
        check("to_gap", 32'(m2_cyc - m1_cyc), 32'd18);
        check("to_flag_time", 32'(to_cyc - m1_cyc), 32'd17);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_moves", 32'(n_moves), 32'd4);
        check("drain_d", 32'(exp_q.size()), 32'd0);
        resp_en = '1;

        // slow balls push the sweep past the vblank fall
        resp_dly = 10;
        push_sweep(4'hF);
        n_moves = 0;
        vblank = 1'b1;
        repeat (20) cyc();
        check("ovr_pre", 32'(overrun), 32'd0);
        check("ovr_busy", 32'(busy), 32'd1);
        vblank = 1'b0;
        cyc();
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (60) cyc();
        check("ovr_moves", 32'(n_moves), 32'd4);
        check("ovr_done", 32'(busy), 32'd0);
        resp_dly = 3;
        push_sweep(4'hF);
        frame(30, 30);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("to_sticky", 32'(timeout_err), 32'd1);
        check("drain_e", 32'(exp_q.size()), 32'd0);

        // asynchronous reset while a move strobe is high
        push_sweep(4'hF);
        vblank = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b0;
        #1;
        check("arst_move", 32'(move), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cur", 32'(cur_ball), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_timeout", 32'(timeout_err), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) dly[i] = 0;
        ball_done = '0; vblank = 1'b0; rot_start = 0;
        cyc();
        cyc();
        rst = 1'b1;
        n_moves = 0;
        repeat (10) cyc();
        check("post_rst_idle", 32'(n_moves), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // short vblank: second rise while busy is queued, fall while busy flags overrun
        push_sweep(4'hF);
        push_sweep(4'hF);
        n_moves = 0;
        vblank = 1'b1;
        cyc();
        check("rst_lat_busy", 32'(busy), 32'd1);
        cyc();
        check("rst_lat_move", 32'(move), 32'd1);
        repeat (3) cyc();
        vblank = 1'b0;
        repeat (5) cyc();
        vblank = 1'b1;
        repeat (60) cyc();
        vblank = 1'b0;
        repeat (10) cyc();
        check("pend_moves", 32'(n_moves), 32'd8);
        check("pend_overrun", 32'(overrun), 32'd1);
        check("pend_busy", 32'(busy), 32'd0);
        check("drain_g", 32'(exp_q.size()), 32'd0);

        // run=0 drops the request
        run = 1'b0;
        frame(30, 10);
        check("norun_moves", 32'(n_moves), 32'd0);
        check("norun_busy", 32'(busy), 32'd0);

        // nothing advances while pixpulse is low
        run = 1'b1;
        pixpulse = 1'b0;
        n_moves = 0;
        vblank = 1'b1;
        repeat (5) cyc();
        check("pix_hold_busy", 32'(busy), 32'd0);
        check("pix_hold_state", 32'(dbg_state), 32'd0);
        pixpulse = 1'b1;
        push_sweep(4'hF);
        cyc();
        check("pix_busy", 32'(busy), 32'd1);
        cyc();
        check("pix_move", 32'(move), 32'd1);
        repeat (28) cyc();
        vblank = 1'b0;
        repeat (10) cyc();
        check("pix_moves", 32'(n_moves), 32'd4);
        check("drain_h", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
